// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage : instruction-decode stage of the 16-bit pipeline.
//
// Decodes the instruction held in IF/ID, drives the register-file read
// addresses, bypasses a same-cycle writeback onto the operands, detects
// load-use hazards (inserting one bubble) and holds the ID/EX register behind
// a valid/ready handshake with flush support. A HALT freezes the input side
// until reset.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_instr/in_ready IF/ID handshake (in_ready combinational)
//   rf_raddr1/2, rf_rdata1/2  register-file read port (async data)
//   wb_we/wb_waddr/wb_wdata   writeback port shared with the register file
//   flush                     kill ID/EX and the current input
//   ex_ready                  EX accepts the ID/EX register
//   out_*                     registered ID/EX contents
//   perf_stalls               stall counter
//
// Configuration macro: ID_PERF_EN builds the saturating stall counter;
// otherwise perf_stalls is tied to zero.
// -----------------------------------------------------------------------------
module id_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] in_instr,
    output logic        in_ready,
    output logic [3:0]  rf_raddr1,
    output logic [3:0]  rf_raddr2,
    input  logic [15:0] rf_rdata1,
    input  logic [15:0] rf_rdata2,
    input  logic        wb_we,
    input  logic [3:0]  wb_waddr,
    input  logic [15:0] wb_wdata,
    input  logic        flush,
    input  logic        ex_ready,
    output logic        out_valid,
    output logic [3:0]  out_op,
    output logic [3:0]  out_rd,
    output logic [15:0] out_a,
    output logic [15:0] out_b,
    output logic [15:0] out_imm,
    output logic        out_we,
    output logic        out_mem_rd,
    output logic        out_mem_wr,
    output logic [15:0] perf_stalls
);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_LW   = 4'h7;
    localparam logic [3:0] OP_SW   = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {RUN, STALL, HALTED} state_t;

    state_t state, state_nxt;

    // instruction fields
    logic [3:0] f_op, f_rd, f_rs1, f_rs2;
    assign f_op  = in_instr[15:12];
    assign f_rd  = in_instr[11:8];
    assign f_rs1 = in_instr[7:4];
    assign f_rs2 = in_instr[3:0];

    // decoded controls
    logic [3:0]  dec_op;
    logic        use1, use2, dec_we, dec_mr, dec_mw, is_halt;
    logic [3:0]  src2;
    logic [15:0] opnd_a, opnd_b, imm_sx;

    always_comb begin
        dec_op  = OP_NOP;
        use1    = 1'b0;
        use2    = 1'b0;
        dec_we  = 1'b0;
        dec_mr  = 1'b0;
        dec_mw  = 1'b0;
        is_halt = 1'b0;
        if (f_op >= 4'h1 && f_op <= OP_XOR) begin
            dec_op = f_op;
            use1   = 1'b1;
            use2   = 1'b1;
            dec_we = 1'b1;
        end else begin
            case (f_op)
                OP_ADDI: begin
                    dec_op = f_op;
                    use1   = 1'b1;
                    dec_we = 1'b1;
                end
                OP_LW: begin
                    dec_op = f_op;
                    use1   = 1'b1;
                    dec_we = 1'b1;
                    dec_mr = 1'b1;
                end
                OP_SW: begin
                    dec_op = f_op;
                    use1   = 1'b1;
                    use2   = 1'b1;
                    dec_mw = 1'b1;
                end
                OP_HALT: begin
                    dec_op  = f_op;
                    is_halt = 1'b1;
                end
                default: dec_op = OP_NOP;
            endcase
        end
    end

    // stores read the data register through the rd field
    assign src2      = (f_op == OP_SW) ? f_rd : f_rs2;
    assign rf_raddr1 = f_rs1;
    assign rf_raddr2 = src2;

    // same-cycle writeback bypass, per operand
    assign opnd_a = (wb_we && (wb_waddr == f_rs1)) ? wb_wdata : rf_rdata1;
    assign opnd_b = (wb_we && (wb_waddr == src2))  ? wb_wdata : rf_rdata2;
    assign imm_sx = {{12{f_rs2[3]}}, f_rs2};

    // load-use: only sources the instruction actually reads count
    logic hazard, advance, take;
    assign hazard  = out_valid && out_mem_rd &&
                     ((use1 && (out_rd == f_rs1)) || (use2 && (out_rd == src2)));
    assign advance = !out_valid || ex_ready;
    assign in_ready = advance && !hazard && (state != HALTED) && !flush;
    assign take     = in_valid && in_ready;

    // FSM
    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (!flush) begin
                    if (in_valid && advance && hazard) state_nxt = STALL;
                    else if (take && is_halt)          state_nxt = HALTED;
                end
            end
            STALL: begin
                // held instruction re-decodes against the bubble; a HALT
                // accepted here still freezes the stage
                if (take && is_halt) state_nxt = HALTED;
                else                 state_nxt = RUN;
            end
            HALTED:  state_nxt = HALTED;
            default: state_nxt = RUN;
        endcase
    end

    // ID/EX register. A hazard or an empty input leaves a bubble; captured
    // operands are held as-is while EX back-pressures.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_op     <= 4'h0;
            out_rd     <= 4'h0;
            out_a      <= 16'h0;
            out_b      <= 16'h0;
            out_imm    <= 16'h0;
            out_we     <= 1'b0;
            out_mem_rd <= 1'b0;
            out_mem_wr <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (advance) begin
            if (take) begin
                out_valid  <= 1'b1;
                out_op     <= dec_op;
                out_rd     <= f_rd;
                out_a      <= opnd_a;
                out_b      <= opnd_b;
                out_imm    <= imm_sx;
                out_we     <= dec_we;
                out_mem_rd <= dec_mr;
                out_mem_wr <= dec_mw;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef ID_PERF_EN
    logic [15:0] stall_cnt;
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= 16'h0;
        else if (in_valid && !in_ready && (state != HALTED) && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'h1;
    end
    assign perf_stalls = stall_cnt;
`else
    assign perf_stalls = 16'h0;
`endif

endmodule
